// File: rtl/i2c_master.sv
// i2c_master: single-byte I2C write/read master; each SCL bit is four quarters of QTR clocks.
// Define I2C_MASTER_RETRY_EN to retry a NACKed address up to three more times before failing.
module i2c_master #(
  parameter int QTR = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       scl,
  inout  wire        sda
);
  typedef enum logic [3:0] {IDLE, START, ADDR, ADDR_ACK, WDATA, WACK, RDATA, RNACK, STOP} state_t;
  state_t state_q, state_d;
  logic [7:0] qcnt_q, qcnt_d, shift_q, shift_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [6:0] addr_q, addr_d;
  logic [2:0] bit_q, bit_d;
  logic [1:0] qtr_q, qtr_d;
  logic rw_q, rw_d, ack_q, ack_d, ack_err_q, ack_err_d, done_q, done_d;
  logic sda_in, sda_oe, tick_end, bit_end, sample, byte_st;
`ifdef I2C_MASTER_RETRY_EN
  logic [1:0] retry_q, retry_d;
  logic again_q, again_d;
`endif
  // a floating line reads as 1
  assign sda_in = (sda === 1'b0) ? 1'b0 : 1'b1;
  assign sda = sda_oe ? 1'b0 : 1'bz;
  assign rdata = rdata_q;
  assign ack_err = ack_err_q;
  assign done = done_q;
  assign busy = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    qcnt_d = qcnt_q;
    qtr_d = qtr_q;
    bit_d = bit_q;
    shift_d = shift_q;
    addr_d = addr_q;
    rw_d = rw_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ack_d = ack_q;
    ack_err_d = ack_err_q;
    done_d = 1'b0;
`ifdef I2C_MASTER_RETRY_EN
    retry_d = retry_q;
    again_d = again_q;
`endif
    tick_end = qcnt_q == 8'(QTR - 1);
    bit_end = tick_end && qtr_q == 2'd3;
    sample = qcnt_q == 8'd0 && qtr_q == 2'd2;
    byte_st = state_q == ADDR || state_q == WDATA || state_q == RDATA;
    scl = (state_q == IDLE) || (state_q == START ? !qtr_q[1] : qtr_q[1]);
    sda_oe = (state_q == START) || ((state_q == ADDR || state_q == WDATA) && !shift_q[7]) ||
             (state_q == STOP && qtr_q != 2'd3);
    if (state_q == IDLE) begin
      qcnt_d = 8'd0;
      qtr_d = 2'd0;
      bit_d = 3'd0;
      if (start && !done_q) begin
        addr_d = addr;
        rw_d = rw;
        wdata_d = wdata;
        ack_err_d = 1'b0;
`ifdef I2C_MASTER_RETRY_EN
        retry_d = 2'd0;
        again_d = 1'b0;
`endif
        state_d = START;
      end
    end else begin
      qcnt_d = tick_end ? 8'd0 : qcnt_q + 8'd1;
      qtr_d = tick_end ? qtr_q + 2'd1 : qtr_q;
      if (sample) begin
        ack_d = sda_in;
        if (state_q == RDATA) shift_d = {shift_q[6:0], sda_in};
      end
      if (bit_end) begin
        bit_d = byte_st ? bit_q + 3'd1 : 3'd0;
        case (state_q)
          START: begin
            shift_d = {addr_q, rw_q};
            state_d = ADDR;
          end
          ADDR, WDATA: begin
            shift_d = {shift_q[6:0], 1'b0};
            if (bit_q == 3'd7) state_d = state_q == ADDR ? ADDR_ACK : WACK;
          end
          ADDR_ACK: begin
            if (!ack_q) begin
              shift_d = wdata_q;
              state_d = rw_q ? RDATA : WDATA;
            end else begin
`ifdef I2C_MASTER_RETRY_EN
              again_d = retry_q != 2'd3;
              retry_d = retry_q + {1'b0, again_d};
              ack_err_d = !again_d;
`else
              ack_err_d = 1'b1;
`endif
              state_d = STOP;
            end
          end
          WACK: begin
            ack_err_d = ack_err_q | ack_q;
            state_d = STOP;
          end
          RDATA: begin
            if (bit_q == 3'd7) begin
              rdata_d = shift_q;
              state_d = RNACK;
            end
          end
          RNACK: state_d = STOP;
          STOP: begin
            state_d = IDLE;
            done_d = 1'b1;
`ifdef I2C_MASTER_RETRY_EN
            if (again_q) begin
              state_d = START;
              done_d = 1'b0;
              again_d = 1'b0;
            end
`endif
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      qcnt_q <= 8'd0;
      qtr_q <= 2'd0;
      bit_q <= 3'd0;
      shift_q <= 8'd0;
      addr_q <= 7'd0;
      rw_q <= 1'b0;
      wdata_q <= 8'd0;
      rdata_q <= 8'd0;
      ack_q <= 1'b0;
      ack_err_q <= 1'b0;
      done_q <= 1'b0;
`ifdef I2C_MASTER_RETRY_EN
      retry_q <= 2'd0;
      again_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      qcnt_q <= qcnt_d;
      qtr_q <= qtr_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      addr_q <= addr_d;
      rw_q <= rw_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q <= ack_d;
      ack_err_q <= ack_err_d;
      done_q <= done_d;
`ifdef I2C_MASTER_RETRY_EN
      retry_q <= retry_d;
      again_q <= again_d;
`endif
    end
  end
endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: randomized scoreboard bench for i2c_master, with a bus-level I2C slave model.
module tb_i2c_master;
  localparam int QTR = 4;
`ifdef I2C_MASTER_RETRY_EN
  localparam int ATT = 4;
`else
  localparam int ATT = 1;
`endif
  typedef struct packed {
    int lat;
    logic aerr;
    logic [7:0] rd;
    int nb;
    logic [3:0][7:0] b;
    int starts;
    int issue;
  } exp_t;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, rw = 1'b0;
  logic [6:0] addr = 7'd0;
  logic [7:0] wdata = 8'd0;
  logic [7:0] rdata;
  logic busy, done, ack_err, scl;
  wire sda;
  logic sl_drv = 1'b0;
  logic [6:0] sl_addr = 7'd0;
  logic sl_dack = 1'b1;
  logic [7:0] sl_data = 8'd0;
  assign sda = sl_drv ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_master #(.QTR(QTR)) dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .rdata(rdata), .busy(busy), .done(done), .ack_err(ack_err), .scl(scl), .sda(sda)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0, miscompares = 0;
  exp_t sb[$];
  logic [7:0] bus_q[$];
  int n_start = 0, n_stop = 0;
  logic [7:0] exp_rd = 8'd0;

  function automatic logic sda_v();
    return (sda === 1'b0) ? 1'b0 : 1'b1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Reference: what one transaction should look like on the bus and at the ports.
  function automatic exp_t model(input bit rwv, input bit [6:0] a, input bit [7:0] wd, input bit hit,
                                 input bit dack, input bit [7:0] sd, input bit [7:0] prev);
    exp_t e;
    e = '0;
    e.b[0] = {a, rwv};
    if (!hit) begin
      e.starts = ATT;
      e.nb = ATT;
      for (int i = 1; i < ATT; i++) e.b[i] = {a, rwv};
      e.aerr = 1'b1;
      e.rd = prev;
      e.lat = ATT * 11 * 4 * QTR + 1;
    end else begin
      e.starts = 1;
      e.nb = 2;
      e.b[1] = rwv ? sd : wd;
      e.aerr = !rwv && !dack;
      e.rd = rwv ? sd : prev;
      e.lat = 20 * 4 * QTR + 1;
    end
    return e;
  endfunction

  // Bus monitor + slave: decodes START/STOP/bits and drives ACKs and read data.
  initial begin
    logic scl_p, sda_p, sv, is_rd, matched;
    logic [7:0] sh;
    int bcnt, nbyte;
    scl_p = 1'b1; sda_p = 1'b1; is_rd = 1'b0; matched = 1'b0; sh = 8'd0; bcnt = 0; nbyte = 0;
    forever begin
      @(negedge clk);
      sv = sda_v();
      if (scl_p && scl && sda_p && !sv) begin
        n_start++; bcnt = 0; nbyte = 0; matched = 1'b0; sl_drv = 1'b0;
      end else if (scl_p && scl && !sda_p && sv) begin
        n_stop++; bcnt = 0; nbyte = 0; sl_drv = 1'b0;
      end else if (!scl_p && scl) begin
        if (bcnt < 8) begin
          sh = {sh[6:0], sv};
          if (bcnt == 7) bus_q.push_back(sh);
        end
        if (bcnt == 8) begin
          bcnt = 0;
          nbyte++;
        end else bcnt++;
      end else if (scl_p && !scl) begin
        if (bcnt == 8) begin
          if (nbyte == 0) begin
            matched = sh[7:1] == sl_addr;
            is_rd = sh[0];
            sl_drv = matched;
          end else sl_drv = nbyte == 1 && !is_rd && matched && sl_dack;
        end else sl_drv = (nbyte == 1 && is_rd && matched) ? !sl_data[7 - bcnt] : 1'b0;
      end
      scl_p = scl;
      sda_p = sv;
    end
  end

  // Scoreboard monitor: every done pulse pops one expectation.
  initial begin
    exp_t e;
    int st_b, sp_b, by_b;
    st_b = 0; sp_b = 0; by_b = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        st_b = n_start; sp_b = n_stop; by_b = bus_q.size();
      end else if (done) begin
        if (sb.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_done: done pulse with no transaction pending at cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          chk("latency", cyc - e.issue, e.lat);
          chk("ack_err", ack_err, e.aerr);
          chk("rdata", rdata, e.rd);
          chk("busy_at_done", busy, 0);
          chk("starts", n_start - st_b, e.starts);
          chk("stops", n_stop - sp_b, e.starts);
          chk("bus_nbytes", bus_q.size() - by_b, e.nb);
          for (int i = 0; i < e.nb && by_b + i < bus_q.size(); i++) chk("bus_byte", bus_q[by_b + i], e.b[i]);
        end
        st_b = n_start; sp_b = n_stop; by_b = bus_q.size();
      end
    end
  end

  task automatic issue(input bit rwv, input bit [6:0] a, input bit [7:0] wd, input bit hit,
                       input bit dack, input bit [7:0] sd, input bit push);
    exp_t e;
    sl_addr = hit ? a : a ^ 7'h55;
    sl_dack = dack;
    sl_data = sd;
    if (push) begin
      e = model(rwv, a, wd, hit, dack, sd, exp_rd);
      exp_rd = e.rd;
      e.issue = cyc;
      sb.push_back(e);
    end
    rw = rwv; addr = a; wdata = wd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("ack_err_cleared", ack_err, 0);
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge clk);
      ok = done;
    end
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL done_timeout: no done within 4000 cycles at cycle %0d", cyc);
    end
  endtask

  task automatic txn(input bit rwv, input bit [6:0] a, input bit [7:0] wd, input bit hit,
                     input bit dack, input bit [7:0] sd);
    bit ok;
    issue(rwv, a, wd, hit, dack, sd, 1'b1);
    wait_done(ok);
    @(negedge clk);
  endtask

  initial begin
    bit ok;
    int stops_before;
    #1 reset = 1'b0;
    #2;
    chk("rst_scl", scl, 1);
    chk("rst_sda", sda_v(), 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ack_err", ack_err, 0);
    chk("rst_rdata", rdata, 8'h00);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    txn(1'b0, 7'h2A, 8'hC3, 1'b1, 1'b1, 8'h00);
    txn(1'b1, 7'h2A, 8'h00, 1'b1, 1'b1, 8'h5A);
    txn(1'b0, 7'h11, 8'h77, 1'b0, 1'b1, 8'h00);
    txn(1'b0, 7'h2A, 8'hE1, 1'b1, 1'b0, 8'h00);
    txn(1'b1, 7'h11, 8'h00, 1'b0, 1'b1, 8'h3C);
    // start while busy, in the done cycle, and one cycle after done
    issue(1'b0, 7'h2A, 8'h96, 1'b1, 1'b1, 8'h00, 1'b1);
    repeat (40) @(negedge clk);
    rw = 1'b1; addr = 7'h33; wdata = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(ok);
    if (ok) begin
      rw = 1'b1; addr = 7'h33; start = 1'b1;
      @(negedge clk);
      chk("start_in_done_ignored", busy, 0);
      issue(1'b1, 7'h2A, 8'h00, 1'b1, 1'b1, 8'hA7, 1'b1);
      wait_done(ok);
      @(negedge clk);
    end
    // reset during ADDR bit 5 (address bit is 1, so SDA is already released)
    issue(1'b0, 7'h2A, 8'hC3, 1'b1, 1'b1, 8'h00, 1'b0);
    repeat (25 * QTR + 1) @(negedge clk);
    chk("pre_abort_scl_low", scl, 0);
    stops_before = n_stop;
    reset = 1'b0;
    #1;
    chk("abort_scl", scl, 1);
    chk("abort_sda", sda_v(), 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    exp_rd = 8'h00;
    @(negedge clk);
    chk("post_abort_idle", busy, 0);
    chk("abort_no_stop", n_stop - stops_before, 0);
    chk("abort_rdata", rdata, 8'h00);
    txn(1'b1, 7'h2A, 8'h00, 1'b1, 1'b1, 8'h81);
    for (int i = 0; i < 20; i++)
      txn(1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)),
          $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)));
    repeat (5) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
